// File: rtl/wb_slave_decoder.sv
// Wishbone slave-side decoder: window decode, routing, default slave, bus-timeout watchdog.
// Optional error log / status register enabled by defining WB_DEC_ERRLOG_EN.
module wb_slave_decoder #(
  parameter int                    DATAW     = 32,
  parameter int                    ADDRW     = 20,
  parameter int                    NSLV      = 2,
  parameter logic [NSLV*ADDRW-1:0] SLV_BASE  = {20'h00000, 20'hE0000},
  parameter logic [NSLV*ADDRW-1:0] SLV_MASK  = {20'h00000, 20'hFFF00},
  parameter int                    TIMEOUT   = 16,
  parameter logic [DATAW-1:0]      DFLT_DATA = 32'hBADC0DE0,
  parameter logic [ADDRW-1:0]      STAT_ADDR = 20'hEFF00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDRW-1:0]      wbm_adr_i,
  input  logic [DATAW-1:0]      wbm_dat_i,
  input  logic                  wbm_we_i,
  input  logic                  wbm_stb_i,
  input  logic                  wbm_cyc_i,
  output logic [DATAW-1:0]      wbm_dat_o,
  output logic                  wbm_ack_o,
  output logic [ADDRW-1:0]      wbs_adr_o,
  output logic [DATAW-1:0]      wbs_dat_o,
  output logic                  wbs_we_o,
  output logic [NSLV-1:0]       wbs_stb_o,
  output logic [NSLV-1:0]       wbs_cyc_o,
  input  logic [NSLV*DATAW-1:0] wbs_dat_i,
  input  logic [NSLV-1:0]       wbs_ack_i,
  output logic                  err_o
);

  localparam int SELW = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int CNTW = $clog2(TIMEOUT);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_BUSY = 3'd1;
  localparam logic [2:0] ST_DFLT = 3'd2;
  localparam logic [2:0] ST_TOUT = 3'd3;
  localparam logic [2:0] ST_STAT = 3'd4;

`ifdef WB_DEC_ERRLOG_EN
  localparam bit STAT_EN = 1'b1;
`else
  localparam bit STAT_EN = 1'b0;
`endif

  logic [2:0]      state;
  logic [SELW-1:0] sel;
  logic [CNTW-1:0] cnt;
  logic            hit;
  logic [SELW-1:0] hit_idx;
  logic            stat_hit;
  logic            req;
  logic [DATAW-1:0] stat_rdata;

  assign req      = wbm_cyc_i & wbm_stb_i;
  assign stat_hit = STAT_EN && (wbm_adr_i == STAT_ADDR);

  // Scan downward so the lowest matching index wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((SLV_MASK[i*ADDRW +: ADDRW] != '0) &&
          ((wbm_adr_i & SLV_MASK[i*ADDRW +: ADDRW])
            == SLV_BASE[i*ADDRW +: ADDRW])) begin
        hit     = 1'b1;
        hit_idx = SELW'(i);
      end
    end
  end

  assign wbs_adr_o = rst_n ? wbm_adr_i : '0;
  assign wbs_dat_o = rst_n ? wbm_dat_i : '0;
  assign wbs_we_o  = rst_n & wbm_we_i;

  always_comb begin
    wbs_stb_o = '0;
    wbs_cyc_o = '0;
    wbm_ack_o = 1'b0;
    wbm_dat_o = '0;
    err_o     = 1'b0;
    unique case (state)
      ST_BUSY: begin
        wbs_cyc_o[sel] = wbm_cyc_i;
        wbs_stb_o[sel] = wbm_stb_i & wbm_cyc_i;
        wbm_ack_o      = wbs_ack_i[sel] & wbm_cyc_i;
        wbm_dat_o      = wbs_dat_i[sel*DATAW +: DATAW];
      end
      ST_DFLT, ST_TOUT: begin
        wbm_ack_o = wbm_cyc_i;
        wbm_dat_o = DFLT_DATA;
        err_o     = wbm_cyc_i;
      end
      ST_STAT: begin
        wbm_ack_o = wbm_cyc_i;
        wbm_dat_o = stat_rdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      sel   <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (req) begin
            if (stat_hit) begin
              state <= ST_STAT;
            end else if (hit) begin
              sel   <= hit_idx;
              state <= ST_BUSY;
            end else begin
              state <= ST_DFLT;
            end
          end
        end
        ST_BUSY: begin
          if (!wbm_cyc_i || wbs_ack_i[sel]) begin
            state <= ST_IDLE;
            sel   <= '0;
            cnt   <= '0;
          end else if (cnt == CNTW'(TIMEOUT - 1)) begin
            state <= ST_TOUT;
            sel   <= '0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNTW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef WB_DEC_ERRLOG_EN
  logic [11:0]      err_cnt;
  logic [ADDRW-1:0] err_adr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
      err_adr <= '0;
    end else if ((state == ST_STAT) && wbm_cyc_i && wbm_we_i) begin
      err_cnt <= '0;
      err_adr <= '0;
    end else if (err_o) begin
      err_adr <= wbm_adr_i;
      if (err_cnt != 12'hFFF)
        err_cnt <= err_cnt + 12'd1;
    end
  end

  assign stat_rdata = DATAW'({err_cnt, err_adr});
`else
  assign stat_rdata = '0;
`endif

endmodule

// File: tb/tb_wb_slave_decoder.sv
// Scoreboard bench for wb_slave_decoder: directed transfers, timeout, abort, reset.
// Slave 1 is the timer window at 20'hE0000; slave 0 covers 20'h1xxxx.
module tb_wb_slave_decoder;
  localparam int DW = 32;
  localparam int AW = 20;
  localparam int NS = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [AW-1:0]    wbm_adr_i = '0;
  logic [DW-1:0]    wbm_dat_i = '0;
  logic             wbm_we_i = 1'b0;
  logic             wbm_stb_i = 1'b0;
  logic             wbm_cyc_i = 1'b0;
  logic [DW-1:0]    wbm_dat_o;
  logic             wbm_ack_o;
  logic [AW-1:0]    wbs_adr_o;
  logic [DW-1:0]    wbs_dat_o;
  logic             wbs_we_o;
  logic [NS-1:0]    wbs_stb_o;
  logic [NS-1:0]    wbs_cyc_o;
  logic [NS*DW-1:0] wbs_dat_i;
  logic [NS-1:0]    wbs_ack_i = '0;
  logic             err_o;

  wb_slave_decoder #(
    .DATAW    (DW),
    .ADDRW    (AW),
    .NSLV     (NS),
    .SLV_BASE ({20'hE0000, 20'h10000}),
    .SLV_MASK ({20'hFFF00, 20'hF0000}),
    .TIMEOUT  (16),
    .DFLT_DATA(32'hBADC0DE0),
    .STAT_ADDR(20'hEFF00)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wbm_adr_i(wbm_adr_i),
    .wbm_dat_i(wbm_dat_i),
    .wbm_we_i (wbm_we_i),
    .wbm_stb_i(wbm_stb_i),
    .wbm_cyc_i(wbm_cyc_i),
    .wbm_dat_o(wbm_dat_o),
    .wbm_ack_o(wbm_ack_o),
    .wbs_adr_o(wbs_adr_o),
    .wbs_dat_o(wbs_dat_o),
    .wbs_we_o (wbs_we_o),
    .wbs_stb_o(wbs_stb_o),
    .wbs_cyc_o(wbs_cyc_o),
    .wbs_dat_i(wbs_dat_i),
    .wbs_ack_i(wbs_ack_i),
    .err_o    (err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] dat;
    logic        err;
  } exp_t;

  int          nvec = 0;
  int          nerr = 0;
  exp_t        sbq[$];
  exp_t        mon_e;
  int          dly[NS];
  logic [31:0] sdat[NS];
  logic [NS-1:0] late_ack = '0;

  assign wbs_dat_i = {sdat[1], sdat[0]};

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Monitor: every master-side ack is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && wbm_ack_o) begin
      if (sbq.size() == 0) begin
        chk("unexpected_ack", 64'd1, 64'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("ack_dat", 64'(wbm_dat_o), 64'(mon_e.dat));
        chk("ack_err", 64'(err_o), 64'(mon_e.err));
      end
    end
  end

  // Slave models: ack after dly[i] strobed cycles (0 = never), plus forced late ack.
  initial begin
    int c[NS];
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++) begin
        if (wbs_cyc_o[i] && wbs_stb_o[i]) c[i]++;
        else c[i] = 0;
        wbs_ack_i[i] = ((dly[i] != 0) && (c[i] == dly[i])) || late_ack[i];
      end
    end
  end

  task automatic start_req(input logic [AW-1:0] a, input logic we,
                           input logic [31:0] d);
    @(posedge clk);
    #1;
    wbm_adr_i = a;
    wbm_we_i  = we;
    wbm_dat_i = d;
    wbm_cyc_i = 1'b1;
    wbm_stb_i = 1'b1;
    #1;
    chk("adr_we_pass", 64'({wbs_adr_o, wbs_we_o}), 64'({a, we}));
    chk("dat_pass", 64'(wbs_dat_o), 64'(d));
  endtask

  task automatic wait_ack(output int lat, output logic [NS-1:0] seen,
                          output int scnt);
    lat  = 0;
    seen = '0;
    scnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      lat++;
      seen |= wbs_stb_o;
      if (wbs_stb_o != '0) scnt++;
      if (wbm_ack_o) return;
    end
    chk("ack_timeout", 64'd1, 64'd0);
  endtask

  task automatic end_req();
    @(posedge clk);
    #1;
    wbm_cyc_i = 1'b0;
    wbm_stb_i = 1'b0;
    wbm_we_i  = 1'b0;
    @(negedge clk);
    chk("ack_err_clear", 64'({wbm_ack_o, err_o}), 64'd0);
  endtask

  task automatic do_xfer(input string nm, input logic [AW-1:0] a,
                         input logic we, input logic [31:0] d,
                         input logic [31:0] edat, input logic eerr,
                         input int elat, input logic [NS-1:0] eseen,
                         input int escnt);
    int            lat;
    logic [NS-1:0] seen;
    int            scnt;
    exp_t          e;
    e.dat = edat;
    e.err = eerr;
    sbq.push_back(e);
    start_req(a, we, d);
    wait_ack(lat, seen, scnt);
    chk({nm, "_lat"}, 64'(lat), 64'(elat));
    chk({nm, "_stb"}, 64'(seen), 64'(eseen));
    chk({nm, "_stbcnt"}, 64'(scnt), 64'(escnt));
    end_req();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    sdat[0] = 32'hA5A50000;
    sdat[1] = 32'h00001234;
    dly[0]  = 1;
    dly[1]  = 3;
    #1;
    chk("rst_outs", 64'({wbs_stb_o, wbs_cyc_o, wbm_ack_o, err_o}), 64'd0);
    chk("rst_dat", 64'(wbm_dat_o), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    do_xfer("tmr_rd", 20'hE0004, 1'b0, 32'h0, 32'h00001234, 1'b0, 4, 2'b10, 3);
    do_xfer("s0_rd", 20'h10020, 1'b0, 32'h0, 32'hA5A50000, 1'b0, 2, 2'b01, 1);
    do_xfer("unm_wr", 20'h40000, 1'b1, 32'hDEADBEEF, 32'hBADC0DE0, 1'b1, 2, 2'b00, 0);
    do_xfer("unm_rd", 20'h40000, 1'b0, 32'h0, 32'hBADC0DE0, 1'b1, 2, 2'b00, 0);

    dly[1] = 0;
    do_xfer("tout", 20'hE0010, 1'b0, 32'h0, 32'hBADC0DE0, 1'b1, 18, 2'b10, 16);
    @(negedge clk);
    late_ack[1] = 1'b1;
    @(negedge clk);
    chk("late_ack", 64'({wbm_ack_o, err_o, wbs_stb_o, wbs_cyc_o}), 64'd0);
    late_ack[1] = 1'b0;

    start_req(20'hE0020, 1'b0, 32'h0);
    repeat (3) @(negedge clk);
    chk("abort_busy_stb", 64'(wbs_stb_o), 64'(2'b10));
    #1 wbm_cyc_i = 1'b0;
    #1;
    chk("abort_drop", 64'({wbs_stb_o, wbs_cyc_o, wbm_ack_o}), 64'd0);
    wbm_stb_i = 1'b0;
    @(negedge clk);
    chk("abort_noack", 64'({wbm_ack_o, err_o}), 64'd0);

    start_req(20'hE0030, 1'b1, 32'h0000CAFE);
    repeat (3) @(negedge clk);
    chk("rstb_busy_cyc", 64'(wbs_cyc_o), 64'(2'b10));
    #1 rst_n = 1'b0;
    #1;
    chk("rstb_outs", 64'({wbs_stb_o, wbs_cyc_o, wbm_ack_o, err_o}), 64'd0);
    chk("rstb_dat", 64'({wbm_dat_o, wbs_adr_o}), 64'd0);
    wbm_cyc_i = 1'b0;
    wbm_stb_i = 1'b0;
    wbm_we_i  = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    dly[1] = 3;
    do_xfer("tmr_rd2", 20'hE0004, 1'b0, 32'h0, 32'h00001234, 1'b0, 4, 2'b10, 3);

`ifdef WB_DEC_ERRLOG_EN
    do_xfer("log_unm1", 20'h40000, 1'b1, 32'h1, 32'hBADC0DE0, 1'b1, 2, 2'b00, 0);
    do_xfer("log_unm2", 20'h50010, 1'b0, 32'h0, 32'hBADC0DE0, 1'b1, 2, 2'b00, 0);
    do_xfer("stat_rd", 20'hEFF00, 1'b0, 32'h0, 32'h00250010, 1'b0, 2, 2'b00, 0);
    do_xfer("stat_wr", 20'hEFF00, 1'b1, 32'h0, 32'h00250010, 1'b0, 2, 2'b00, 0);
    do_xfer("stat_rd2", 20'hEFF00, 1'b0, 32'h0, 32'h00000000, 1'b0, 2, 2'b00, 0);
`else
    do_xfer("stat_unm", 20'hEFF00, 1'b0, 32'h0, 32'hBADC0DE0, 1'b1, 2, 2'b00, 0);
`endif

    repeat (2) @(negedge clk);
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
